// File: rtl/bcd_seven_seg_scanner.sv
// rtl/bcd_seven_seg_scanner.sv - binary to BCD converter with multiplexed seven-segment scan
module bcd_seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int IN_WIDTH    = 13,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] value,
  input  logic [2:0]          dp_pos,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                dp,
  output logic                busy,
  output logic                overflow
);

  // BCD accumulator holds every decimal digit IN_WIDTH bits can produce,
  // i.e. ceil(IN_WIDTH*0.302+1) nibbles, and never fewer than DIGITS.
  localparam int NIB     = (IN_WIDTH * 302 + 1999) / 1000;
  localparam int ACC_NIB = (NIB > DIGITS) ? NIB : DIGITS;
  localparam int ACC_W   = 4 * ACC_NIB;
  localparam int CNT_W   = $clog2(IN_WIDTH + 1);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IN_WIDTH-1:0]   shift_reg;
  logic [IN_WIDTH-1:0]   sampled;
  logic [ACC_W-1:0]      bcd;
  logic [ACC_W-1:0]      bcd_adj;
  logic [CNT_W-1:0]      bit_cnt;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   upper;
  logic                  ovf_r;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [3:0]            nib;
  logic                  blank_cur;
  logic [6:0]            seg_r;
  logic [DIGITS-1:0]     an_r;
  logic                  dp_r;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_OFF;
    endcase
  endfunction

  // Converter state register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Converter next-state: sample, shift IN_WIDTH times, commit, repeat.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE:    state_next = CONVERT;
      CONVERT: begin
        busy = 1'b1;
        if (bit_cnt == CNT_W'(IN_WIDTH - 1)) state_next = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to each nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < ACC_NIB; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  // Double-dabble datapath; display and overflow change only in COMMIT so a
  // scan never mixes digits from two different conversions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      sampled   <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      disp      <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shift_reg <= value;
          sampled   <= value;
          bcd       <= '0;
          bit_cnt   <= '0;
        end
        CONVERT: begin
          bcd       <= {bcd_adj[ACC_W-2:0], shift_reg[IN_WIDTH-1]};
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end
        COMMIT: begin
          disp  <= bcd[4*DIGITS-1:0];
          ovf_r <= (64'(sampled) >= LIMIT);
        end
        default: ;
      endcase
    end
  end

  // Refresh prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      if (idx == IDX_W'(DIGITS - 1)) idx <= '0;
      else                           idx <= idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Current nibble and leading-zero test (this digit and all above are zero).
  always_comb begin
    nib       = disp[4*idx +: 4];
    upper     = disp >> (4 * idx);
    blank_cur = (BLANK_LZ != 0) && (idx != '0) && (upper == '0);
  end

  // Registered pin drivers; overflow dashes override blanking, dp unaffected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_r <= SEG_OFF;
      an_r  <= '1;
      dp_r  <= 1'b1;
    end else begin
      an_r <= ~(DIGITS'(1) << idx);
      if (ovf_r)          seg_r <= SEG_DASH;
      else if (blank_cur) seg_r <= SEG_OFF;
      else                seg_r <= decode(nib);
      dp_r <= !(dp_pos == 3'(idx));
    end
  end

  assign seg      = seg_r;
  assign an       = an_r;
  assign dp       = dp_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// tb/tb_bcd_seven_seg_scanner.sv - directed scoreboard bench for bcd_seven_seg_scanner
module tb_bcd_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] value;
  logic [2:0]  dp_pos;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic [2:0] an_c;
  logic       dp_a, dp_b, dp_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  bcd_seven_seg_scanner #(.DIGITS(4), .IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(1)) u_dut (
    .clk(clk), .reset(reset), .value(value), .dp_pos(dp_pos),
    .seg(seg_a), .an(an_a), .dp(dp_a), .busy(busy_a), .overflow(ovf_a));

  bcd_seven_seg_scanner #(.DIGITS(4), .IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(0)) u_nolz (
    .clk(clk), .reset(reset), .value(value), .dp_pos(dp_pos),
    .seg(seg_b), .an(an_b), .dp(dp_b), .busy(busy_b), .overflow(ovf_b));

  bcd_seven_seg_scanner #(.DIGITS(3), .IN_WIDTH(13), .REFRESH_DIV(4), .BLANK_LZ(1)) u_d3 (
    .clk(clk), .reset(reset), .value(value), .dp_pos(dp_pos),
    .seg(seg_c), .an(an_c), .dp(dp_c), .busy(busy_c), .overflow(ovf_c));

  int         sel;
  logic [6:0] obs_seg;
  logic [3:0] obs_an;
  logic       obs_dp, obs_busy, obs_ovf;

  always_comb begin
    obs_seg = seg_a; obs_an = an_a; obs_dp = dp_a; obs_busy = busy_a; obs_ovf = ovf_a;
    case (sel)
      1: begin obs_seg = seg_b; obs_an = an_b; obs_dp = dp_b; obs_busy = busy_b; obs_ovf = ovf_b; end
      2: begin obs_seg = seg_c; obs_an = {1'b1, an_c}; obs_dp = dp_c; obs_busy = busy_c; obs_ovf = ovf_c; end
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] prev_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int s, input int val, input int i);
    int nd  = (s == 2) ? 3 : 4;
    bit blz = (s != 1);
    if (val >= p10(nd)) return 7'b0111111;
    if (blz && i > 0 && (val / p10(i)) == 0) return 7'h7F;
    return dec((val / p10(i)) % 10);
  endfunction

  task automatic push_scan(input int s, input int val, input int dpp);
    exp_t e;
    int nd = (s == 2) ? 3 : 4;
    for (int i = 0; i < nd; i++) begin
      e.an  = ~(4'b0001 << i);
      e.seg = model_seg(s, val, i);
      e.dp  = (i == dpp) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic check_scan(input int s, input string tag);
    exp_t e;
    int hold;
    sel = s;
    @(negedge clk);
    prev_an = obs_an;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int k = 0; k < 64; k++) begin
        if (obs_an === e.an && prev_an !== e.an) break;
        prev_an = obs_an;
        @(negedge clk);
      end
      chk({tag, "_an"}, obs_an, e.an);
      chk({tag, "_seg"}, obs_seg, e.seg);
      chk({tag, "_dp"}, obs_dp, e.dp);
      hold = 1;
      for (int k = 0; k < 16; k++) begin
        prev_an = obs_an;
        @(negedge clk);
        if (obs_an !== e.an) break;
        hold++;
      end
      chk({tag, "_hold"}, hold, 4);
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge clk);
  endtask

  initial begin
    bit saw5;
    sel    = 0;
    reset  = 1'b1;
    value  = 13'd1234;
    dp_pos = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_seg", obs_seg, 7'h7F);
      chk("rst_an", obs_an, 4'hF);
      chk("rst_dp", obs_dp, 1'b1);
      chk("rst_busy", obs_busy, 1'b0);
      chk("rst_ovf", obs_ovf, 1'b0);
    end

    // Latency: sample on edge 1, commit on edge 15, pins on edge 16.
    sel   = 0;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lat_busy1", obs_busy, 1'b1);
    repeat (13) @(posedge clk);
    @(negedge clk);
    chk("lat_busy14", obs_busy, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("lat_busy15", obs_busy, 1'b0);
    chk("lat_an15", obs_an, 4'b0111);
    chk("lat_seg15", obs_seg, 7'h7F);
    @(posedge clk); @(negedge clk);
    chk("lat_an16", obs_an, 4'b0111);
    chk("lat_seg16", obs_seg, 7'b1111001);
    push_scan(0, 1234, 7);
    check_scan(0, "t2");

    value = 13'd7;
    settle();
    push_scan(0, 7, 7);
    check_scan(0, "t3lz");
    push_scan(1, 7, 7);
    check_scan(1, "t3nolz");

    value = 13'd1000;
    settle();
    sel = 2; @(negedge clk);
    chk("t4_ovf_d3", obs_ovf, 1'b1);
    sel = 0; @(negedge clk);
    chk("t4_ovf_d4", obs_ovf, 1'b0);
    push_scan(2, 1000, 7);
    check_scan(2, "t4ovf");
    push_scan(0, 1000, 7);
    check_scan(0, "t4d4");
    value = 13'd999;
    settle();
    sel = 2; @(negedge clk);
    chk("t4_ovf999", obs_ovf, 1'b0);
    push_scan(2, 999, 7);
    check_scan(2, "t4nines");

    value  = 13'd42;
    dp_pos = 3'd2;
    settle();
    push_scan(0, 42, 2);
    check_scan(0, "t5dp2");
    dp_pos = 3'd5;
    repeat (2) @(posedge clk);
    push_scan(0, 42, 5);
    check_scan(0, "t5dp5");

    // Reset five cycles into converting 8191; release with value 5.
    dp_pos = 3'd7;
    value  = 13'd8191;
    sel    = 0;
    @(negedge clk);
    for (int k = 0; k < 40 && obs_busy !== 1'b0; k++) @(negedge clk);
    for (int k = 0; k < 40 && obs_busy !== 1'b1; k++) @(negedge clk);
    chk("t6_busy_start", obs_busy, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    value = 13'd5;
    #1;
    chk("t6_rst_seg", obs_seg, 7'h7F);
    chk("t6_rst_an", obs_an, 4'hF);
    chk("t6_rst_dp", obs_dp, 1'b1);
    chk("t6_rst_busy", obs_busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw5  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (obs_an === 4'b1110) begin
        chk("t6_d0", (obs_seg === 7'b1000000) || (obs_seg === 7'b0010010), 1);
        if (obs_seg === 7'b0010010) saw5 = 1'b1;
      end else begin
        chk("t6_blank", obs_seg, 7'h7F);
      end
    end
    chk("t6_saw5", saw5, 1'b1);
    push_scan(0, 5, 7);
    check_scan(0, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
